// File: rtl/pipe_run_ctrl.sv
// rtl/pipe_run_ctrl.sv - run control, halt sequencing and performance counters for the pipelined core
//
// Purpose:
//   Gates instruction fetch and pipeline advance. Execution starts on a start
//   pulse. It stops when an EBREAK or ECALL retires, or when the cycle budget
//   runs out. Before halting, the block drains the instructions still in flight.
//   It also exposes the cycle, retire and stall counters and the halt cause.
//
// Optional feature macro: PIPE_RUN_CTRL_STALL_CNT_EN
//   Defined   : stall_cnt counts stall cycles spent in RUN or DRAIN.
//   Undefined : stall_cnt is tied to 0 and the stall input is unused.
//
// Ports:
//   clk          in   core clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   pulse that leaves IDLE and begins execution
//   clear        in   synchronous return to IDLE with all counters zeroed
//   retire_valid in   an instruction leaves WB this cycle
//   retire_instr in   encoding of the retiring instruction
//   stall        in   hazard unit is stalling IF/ID this cycle
//   fetch_en     out  IF may fetch / advance the PC
//   pipe_en      out  pipeline registers may advance
//   halted       out  block is in HALTED
//   halt_cause   out  00 none, 01 EBREAK, 10 ECALL, 11 timeout
//   cycle_cnt    out  cycles spent in RUN and DRAIN
//   instret_cnt  out  retired instructions
//   stall_cnt    out  stall cycles spent in RUN and DRAIN
module pipe_run_ctrl #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 12,
  parameter int DRAIN_CYC  = 4,
  parameter int XLEN       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             retire_valid,
  input  logic [XLEN-1:0]  retire_instr,
  input  logic             stall,
  output logic             fetch_en,
  output logic             pipe_en,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;

  localparam logic [XLEN-1:0]  INSTR_EBREAK = XLEN'(32'h00100073);
  localparam logic [XLEN-1:0]  INSTR_ECALL  = XLEN'(32'h00000073);
  localparam logic [CNT_W-1:0] CNT_ALL_ONES = '1;
  // Only compared against when MAX_CYCLES != 0, so the wrap for 0 never matters.
  localparam logic [CNT_W-1:0] TIMEOUT_AT   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [3:0]       DRAIN_LOAD   = 4'(DRAIN_CYC - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_ALL_ONES) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             fetch_en_q, fetch_en_d;
  logic             pipe_en_q, pipe_en_d;
  logic             halted_q, halted_d;
  logic             active;
  logic             is_ebreak, is_ecall, timeout_hit;

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    cause_d     = cause_q;
    cycle_d     = cycle_q;
    instret_d   = instret_q;
    active      = (state_q == S_RUN) || (state_q == S_DRAIN);
    is_ebreak   = retire_valid && (retire_instr == INSTR_EBREAK);
    is_ecall    = retire_valid && (retire_instr == INSTR_ECALL);
    timeout_hit = (MAX_CYCLES != 0) && (cycle_q == TIMEOUT_AT);

    if (clear) begin
      state_d   = S_IDLE;
      drain_d   = '0;
      cause_d   = 2'b00;
      cycle_d   = '0;
      instret_d = '0;
    end else begin
      if (active) begin
        cycle_d = sat_inc(cycle_q);
        if (retire_valid) instret_d = sat_inc(instret_q);
      end
      unique case (state_q)
        S_IDLE: begin
          if (start) state_d = S_RUN;
        end
        S_RUN: begin
          // Retire-based causes win over the timeout on the same cycle.
          if (is_ebreak || is_ecall || timeout_hit) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_LOAD;
            cause_d = is_ebreak ? 2'b01 : (is_ecall ? 2'b10 : 2'b11);
          end
        end
        S_DRAIN: begin
          if (drain_q == 4'd0) state_d = S_HALTED;
          else                 drain_d = drain_q - 4'd1;
        end
        S_HALTED: begin
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are registered: they follow the state being entered.
    fetch_en_d = (state_d == S_RUN);
    pipe_en_d  = (state_d == S_RUN) || (state_d == S_DRAIN);
    halted_d   = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      drain_q    <= '0;
      cause_q    <= 2'b00;
      cycle_q    <= '0;
      instret_q  <= '0;
      fetch_en_q <= 1'b0;
      pipe_en_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      cause_q    <= cause_d;
      cycle_q    <= cycle_d;
      instret_q  <= instret_d;
      fetch_en_q <= fetch_en_d;
      pipe_en_q  <= pipe_en_d;
      halted_q   <= halted_d;
    end
  end

`ifdef PIPE_RUN_CTRL_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (clear)                stall_d = '0;
    else if (active && stall) stall_d = sat_inc(stall_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign stall_cnt    = '0;
`endif

  assign fetch_en    = fetch_en_q;
  assign pipe_en     = pipe_en_q;
  assign halted      = halted_q;
  assign halt_cause  = cause_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// tb/tb_pipe_run_ctrl.sv - self-checking bench for pipe_run_ctrl
module tb_pipe_run_ctrl;
  localparam int CNT_W      = 32;
  localparam int MAX_CYCLES = 12;
  localparam int DRAIN_CYC  = 4;
  localparam int XLEN       = 32;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] ECALL  = 32'h00000073;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic             clk = 1'b0;
  logic             rst_n, start, clear, retire_valid, stall;
  logic [XLEN-1:0]  retire_instr;
  logic             fetch_en, pipe_en, halted;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt, stall_cnt;

  int checks = 0;
  int failures = 0;

  // Per-cycle stimulus for one run; index c is the c-th cycle after start.
  logic        rv_a  [1:32];
  logic [31:0] ins_a [1:32];
  logic        st_a  [1:32];

  pipe_run_ctrl #(.CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES), .DRAIN_CYC(DRAIN_CYC), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .retire_valid(retire_valid), .retire_instr(retire_instr), .stall(stall),
    .fetch_en(fetch_en), .pipe_en(pipe_en), .halted(halted), .halt_cause(halt_cause),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_quiet();
    for (int c = 1; c <= 32; c++) begin
      rv_a[c] = 1'b0; ins_a[c] = NOP; st_a[c] = 1'b0;
    end
  endtask

  task automatic fill_random();
    logic [31:0] tmp;
    int r;
    for (int c = 1; c <= 32; c++) begin
      rv_a[c] = 1'($urandom_range(0, 1));
      st_a[c] = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 99);
      tmp = $urandom;
      if (r < 5)       ins_a[c] = EBREAK;
      else if (r < 10) ins_a[c] = ECALL;
      else             ins_a[c] = {tmp[31:7], 7'b0110011};
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1; start = 1'b0; retire_valid = 1'b0; stall = 1'b0;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Starts a run from IDLE and replays the stimulus arrays, comparing every
  // cycle with a cycle-index model: halt step k is the first retiring
  // EBREAK/ECALL within the budget, else the budget itself.
  task automatic run_scenario(input string name);
    int k, exp_instret, exp_stall, exp_cyc;
    logic [1:0] cause, exp_cause;
    k = MAX_CYCLES;
    cause = 2'b11;
    for (int c = 1; c <= MAX_CYCLES; c++) begin
      if (rv_a[c] && ins_a[c] == EBREAK) begin k = c; cause = 2'b01; break; end
      if (rv_a[c] && ins_a[c] == ECALL)  begin k = c; cause = 2'b10; break; end
    end
    exp_instret = 0;
    exp_stall = 0;
    for (int c = 1; c <= k + DRAIN_CYC; c++) begin
      exp_instret += int'(rv_a[c]);
      exp_stall   += int'(st_a[c]);
    end
`ifndef PIPE_RUN_CTRL_STALL_CNT_EN
    exp_stall = 0;
`endif

    @(negedge clk);
    checks++;
    if ({fetch_en, pipe_en, halted} !== 3'b000) begin
      failures++;
      $display("FAIL %s idle_before_start got=%b exp=000", name, {fetch_en, pipe_en, halted});
    end
    start = 1'b1; retire_valid = 1'b0; stall = 1'b0;

    for (int c = 1; c <= k + DRAIN_CYC + 2; c++) begin
      @(negedge clk);
      exp_cause = (c <= k) ? 2'b00 : cause;
      exp_cyc   = (c - 1 <= k + DRAIN_CYC) ? c - 1 : k + DRAIN_CYC;
      checks += 5;
      if (fetch_en !== 1'(c <= k)) begin
        failures++;
        $display("FAIL %s fetch_en cyc%0d got=%b exp=%b", name, c, fetch_en, 1'(c <= k));
      end
      if (pipe_en !== 1'(c <= k + DRAIN_CYC)) begin
        failures++;
        $display("FAIL %s pipe_en cyc%0d got=%b exp=%b", name, c, pipe_en, 1'(c <= k + DRAIN_CYC));
      end
      if (halted !== 1'(c > k + DRAIN_CYC)) begin
        failures++;
        $display("FAIL %s halted cyc%0d got=%b exp=%b", name, c, halted, 1'(c > k + DRAIN_CYC));
      end
      if (halt_cause !== exp_cause) begin
        failures++;
        $display("FAIL %s halt_cause cyc%0d got=%b exp=%b", name, c, halt_cause, exp_cause);
      end
      if (cycle_cnt !== CNT_W'(exp_cyc)) begin
        failures++;
        $display("FAIL %s cycle_cnt cyc%0d got=%0d exp=%0d", name, c, cycle_cnt, exp_cyc);
      end
      retire_valid = rv_a[c];
      retire_instr = ins_a[c];
      stall        = st_a[c];
      start        = 1'($urandom_range(0, 1));
    end

    @(negedge clk);
    start = 1'b0; retire_valid = 1'b0; stall = 1'b0;
    checks += 4;
    if (halted !== 1'b1 || halt_cause !== cause) begin
      failures++;
      $display("FAIL %s final_halt got=%b/%b exp=1/%b", name, halted, halt_cause, cause);
    end
    if (cycle_cnt !== CNT_W'(k + DRAIN_CYC)) begin
      failures++;
      $display("FAIL %s final_cycle_cnt got=%0d exp=%0d", name, cycle_cnt, k + DRAIN_CYC);
    end
    if (instret_cnt !== CNT_W'(exp_instret)) begin
      failures++;
      $display("FAIL %s final_instret_cnt got=%0d exp=%0d", name, instret_cnt, exp_instret);
    end
    if (stall_cnt !== CNT_W'(exp_stall)) begin
      failures++;
      $display("FAIL %s final_stall_cnt got=%0d exp=%0d", name, stall_cnt, exp_stall);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; retire_valid = 1'b0;
    retire_instr = NOP; stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({fetch_en, pipe_en, halted, halt_cause, cycle_cnt, instret_cnt, stall_cnt} !== '0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d got fe=%b pe=%b h=%b hc=%b cyc=%0d ret=%0d st=%0d exp all 0",
                 c, fetch_en, pipe_en, halted, halt_cause, cycle_cnt, instret_cnt, stall_cnt);
      end
    end
  endtask

  task automatic test_ebreak();
    fill_quiet();
    for (int c = 1; c <= 5; c++) rv_a[c] = 1'b1;
    ins_a[5] = EBREAK;
    run_scenario("ebreak");
  endtask

  task automatic test_timeout();
    pulse_clear();
    fill_quiet();
    run_scenario("timeout");
  endtask

  task automatic test_coincident();
    pulse_clear();
    fill_quiet();
    rv_a[MAX_CYCLES] = 1'b1; ins_a[MAX_CYCLES] = ECALL;
    rv_a[MAX_CYCLES + 2] = 1'b1; ins_a[MAX_CYCLES + 2] = EBREAK;
    run_scenario("coincident");
  endtask

  task automatic test_stall();
    pulse_clear();
    fill_quiet();
    st_a[2] = 1'b1; st_a[3] = 1'b1; st_a[4] = 1'b1;
    run_scenario("stall3");
  endtask

  task automatic test_clear_drain();
    pulse_clear();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; retire_valid = 1'b1; retire_instr = EBREAK;
    @(negedge clk);
    retire_valid = 1'b0; retire_instr = NOP;
    checks++;
    if ({fetch_en, pipe_en, halt_cause} !== 4'b0101) begin
      failures++;
      $display("FAIL clear_drain in_drain got fe=%b pe=%b hc=%b exp 0/1/01", fetch_en, pipe_en, halt_cause);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if ({fetch_en, pipe_en, halted, halt_cause, cycle_cnt, instret_cnt, stall_cnt} !== '0) begin
      failures++;
      $display("FAIL clear_drain after_clear got fe=%b pe=%b h=%b hc=%b cyc=%0d ret=%0d exp all 0",
               fetch_en, pipe_en, halted, halt_cause, cycle_cnt, instret_cnt);
    end
    fill_random();
    run_scenario("after_clear");
  endtask

  task automatic test_reset_mid_run();
    pulse_clear();
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b0; retire_valid = 1'b1; retire_instr = NOP; stall = 1'b1;
    end
    checks++;
    if (fetch_en !== 1'b1 || cycle_cnt !== CNT_W'(2)) begin
      failures++;
      $display("FAIL reset_mid running got fe=%b cyc=%0d exp 1/2", fetch_en, cycle_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({fetch_en, pipe_en, halted, halt_cause, cycle_cnt, instret_cnt, stall_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_mid async got fe=%b pe=%b cyc=%0d ret=%0d st=%0d exp all 0",
               fetch_en, pipe_en, cycle_cnt, instret_cnt, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1; retire_valid = 1'b0; stall = 1'b0;
    @(negedge clk);
    checks++;
    if ({fetch_en, pipe_en, halted, cycle_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_mid idle_after got fe=%b pe=%b h=%b cyc=%0d exp all 0",
               fetch_en, pipe_en, halted, cycle_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      pulse_clear();
      fill_random();
      run_scenario("random");
    end
  endtask

  initial begin
    test_reset();
    test_ebreak();
    test_timeout();
    test_coincident();
    test_stall();
    test_clear_drain();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
